// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 1024x768@60 timing constants and VRAM arbiter types
package vga_pkg;

    localparam int H_PIXELS = 1344;
    localparam int V_LINES  = 806;
    localparam int BLACK_H  = 320;
    localparam int BLACK_V  = 38;

    // who issued the read that is travelling through the memory pipeline
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    // command currently on the VRAM port
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISP    = 2'd1,
        ST_HOST_RD = 2'd2,
        ST_HOST_WR = 2'd3
    } arb_state_t;

endpackage

// File: rtl/vram_rd_pipe.sv
// rtl/vram_rd_pipe.sv - owner-tag pipeline routing VRAM read data to display or host
module vram_rd_pipe
    import vga_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  owner_t            issue_tag_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_valid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_rvalid_o
);

    owner_t tag_q1;
    owner_t tag_q2;

    // tag_q1 follows the command on the memory port, tag_q2 the cycle its data appears
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tag_q1 <= OWN_NONE;
            tag_q2 <= OWN_NONE;
        end else begin
            tag_q1 <= issue_tag_i;
            tag_q2 <= tag_q1;
        end
    end

    // capture returning data for its owner; the other data output keeps its value
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            disp_data_o   <= '0;
            disp_valid_o  <= 1'b0;
            host_rdata_o  <= '0;
            host_rvalid_o <= 1'b0;
        end else begin
            disp_valid_o  <= (tag_q2 == OWN_DISP);
            host_rvalid_o <= (tag_q2 == OWN_HOST);
            if (tag_q2 == OWN_DISP) begin
                disp_data_o <= mem_rdata_i;
            end
            if (tag_q2 == OWN_HOST) begin
                host_rdata_o <= mem_rdata_i;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display-priority VRAM arbiter; VRAM_ARB_VBLANK_LOCK_EN limits host to vblank
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 1344,
    parameter int WAIT_W   = 12
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [10:0]       vc_i,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_valid_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_rvalid_o,
    output logic              host_starved_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    owner_t            issue_tag;
    logic              locked;
    logic [WAIT_W-1:0] wait_cnt;

`ifdef VRAM_ARB_VBLANK_LOCK_EN
    // host only touches VRAM while the beam is in vertical blanking
    assign locked = (vc_i >= 11'(BLACK_V));
`else
    logic vc_unused;
    assign vc_unused = ^vc_i;
    assign locked    = 1'b0;
`endif

    // display always wins; host takes any cycle left free
    assign host_gnt_o = rstn_i & ~disp_req_i & host_req_i & ~locked;

    // decode the cycle-N winner into next state and read-owner tag
    always_comb begin
        state_d   = ST_IDLE;
        issue_tag = OWN_NONE;
        if (disp_req_i) begin
            state_d   = ST_DISP;
            issue_tag = OWN_DISP;
        end else if (host_gnt_o) begin
            if (host_we_i) begin
                state_d = ST_HOST_WR;
            end else begin
                state_d   = ST_HOST_RD;
                issue_tag = OWN_HOST;
            end
        end
    end

    // arbiter FSM with registered memory address and write data
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q <= state_d;
            case (state_d)
                ST_DISP: begin
                    mem_addr_o <= disp_addr_i;
                end
                ST_HOST_RD: begin
                    mem_addr_o <= host_addr_i;
                end
                ST_HOST_WR: begin
                    mem_addr_o  <= host_addr_i;
                    mem_wdata_o <= host_wdata_i;
                end
                default: begin
                    mem_addr_o  <= mem_addr_o;
                    mem_wdata_o <= mem_wdata_o;
                end
            endcase
        end
    end

    assign mem_en_o = (state_q != ST_IDLE);
    assign mem_we_o = (state_q == ST_HOST_WR);

    // count cycles the host sits ungranted; flag once when a full line has passed
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_cnt       <= '0;
            host_starved_o <= 1'b0;
        end else if (host_req_i && !host_gnt_o) begin
            if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            host_starved_o <= (wait_cnt == WAIT_W'(MAX_WAIT - 1));
        end else begin
            wait_cnt       <= '0;
            host_starved_o <= 1'b0;
        end
    end

    vram_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .issue_tag_i   (issue_tag),
        .mem_rdata_i   (mem_rdata_i),
        .disp_data_o   (disp_data_o),
        .disp_valid_o  (disp_valid_o),
        .host_rdata_o  (host_rdata_o),
        .host_rvalid_o (host_rvalid_o)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

    localparam int MAX_WAIT = 1344;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [10:0] vc_i = '0;
    logic        disp_req_i = 1'b0;
    logic [15:0] disp_addr_i = '0;
    logic [7:0]  disp_data_o;
    logic        disp_valid_o;
    logic        host_req_i = 1'b0;
    logic        host_we_i = 1'b0;
    logic [15:0] host_addr_i = '0;
    logic [7:0]  host_wdata_i = '0;
    logic        host_gnt_o;
    logic [7:0]  host_rdata_o;
    logic        host_rvalid_o;
    logic        host_starved_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    vram_arbiter #(
        .ADDR_W(16), .DATA_W(8), .MAX_WAIT(MAX_WAIT), .WAIT_W(12)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .vc_i(vc_i),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
        .disp_data_o(disp_data_o), .disp_valid_o(disp_valid_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o),
        .host_rdata_o(host_rdata_o), .host_rvalid_o(host_rvalid_o),
        .host_starved_o(host_starved_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // power-up VRAM contents: 0x0010 holds 0xA5
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    // VRAM macro model: synchronous, read data one cycle after enable
    logic [7:0] vram [int];
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) vram[int'(mem_addr_o)] = mem_wdata_o;
            else mem_rdata_i <= vram.exists(int'(mem_addr_o)) ? vram[int'(mem_addr_o)] : init_val(mem_addr_o);
        end
    end

    // reference model: memory image updated in request order, returns due 3 cycles after request
    typedef struct { int due; logic [7:0] data; } exp_t;
    exp_t       dq[$];
    exp_t       hq[$];
    logic [7:0] ref_mem [int];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         wcnt;
    int         starve_due;
    logic       nxt_men, nxt_mwe;
    logic       exp_gnt, exp_dv, exp_hv, exp_men, exp_mwe, exp_starved;
    logic [7:0] exp_dd, exp_hd;
    logic       obs_gnt, obs_dv, obs_hv, obs_men, obs_mwe, obs_starved;
    logic [7:0] obs_dd, obs_hd, obs_mwd;
    logic [15:0] obs_maddr;

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic model_reset;
        dq.delete();
        hq.delete();
        exp_dd = '0; exp_hd = '0;
        nxt_men = 1'b0; nxt_mwe = 1'b0;
        wcnt = 0; starve_due = -1;
    endtask

    // drive one clock cycle, predict outputs for it, sample DUT at the falling edge
    task automatic cycle(input logic d, input logic [15:0] da, input logic hr, input logic hwe,
                         input logic [15:0] ha, input logic [7:0] hwd, input logic [10:0] vc);
        logic lock;
        disp_req_i = d; disp_addr_i = da; host_req_i = hr; host_we_i = hwe;
        host_addr_i = ha; host_wdata_i = hwd; vc_i = vc;
`ifdef VRAM_ARB_VBLANK_LOCK_EN
        lock = (vc >= 11'd38);
`else
        lock = 1'b0;
`endif
        exp_gnt = hr && !d && !lock;
        exp_men = nxt_men;
        exp_mwe = nxt_mwe;
        exp_dv = (dq.size() != 0 && dq[0].due == cyc);
        if (exp_dv) begin exp_dd = dq[0].data; void'(dq.pop_front()); end
        exp_hv = (hq.size() != 0 && hq[0].due == cyc);
        if (exp_hv) begin exp_hd = hq[0].data; void'(hq.pop_front()); end
        exp_starved = (starve_due == cyc);
        @(negedge clk_i);
        obs_gnt = host_gnt_o; obs_dv = disp_valid_o; obs_dd = disp_data_o;
        obs_hv = host_rvalid_o; obs_hd = host_rdata_o; obs_men = mem_en_o;
        obs_mwe = mem_we_o; obs_maddr = mem_addr_o; obs_mwd = mem_wdata_o;
        obs_starved = host_starved_o;
        nxt_men = d || exp_gnt;
        nxt_mwe = !d && exp_gnt && hwe;
        if (d) dq.push_back('{due: cyc + 3, data: ref_rd(da)});
        else if (exp_gnt) begin
            if (hwe) ref_mem[int'(ha)] = hwd;
            else hq.push_back('{due: cyc + 3, data: ref_rd(ha)});
        end
        if (hr && !exp_gnt) begin
            if (wcnt < MAX_WAIT) begin
                wcnt++;
                if (wcnt == MAX_WAIT) starve_due = cyc + 1;
            end
        end else wcnt = 0;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
    endtask

    task automatic test_reset;
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== 26'h0) begin
            bad++; $display("FAIL reset_mem got=%h exp=0", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o});
        end
        total++;
        if ({disp_valid_o, disp_data_o, host_rvalid_o, host_rdata_o} !== 18'h0) begin
            bad++; $display("FAIL reset_rd got=%h exp=0", {disp_valid_o, disp_data_o, host_rvalid_o, host_rdata_o});
        end
        total++;
        if ({host_gnt_o, host_starved_o} !== 2'b00) begin
            bad++; $display("FAIL reset_host got=%b exp=00", {host_gnt_o, host_starved_o});
        end
        rstn_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic test_disp_read;
        cycle(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
        total++;
        if ({obs_men, obs_mwe, obs_maddr} !== {1'b1, 1'b0, 16'h0010}) begin
            bad++; $display("FAIL disp_cmd got=%b%b %h exp=10 0010", obs_men, obs_mwe, obs_maddr);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
        total++;
        if (obs_dv !== 1'b0) begin bad++; $display("FAIL disp_early got=%b exp=0", obs_dv); end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
        total++;
        if ({obs_dv, obs_dd, obs_hv} !== {1'b1, 8'hA5, 1'b0}) begin
            bad++; $display("FAIL disp_ret got=%b %h %b exp=1 a5 0", obs_dv, obs_dd, obs_hv);
        end
        idle(3);
    endtask

    task automatic test_host_write_read;
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 8'h3C, 11'd0);
        total++;
        if (obs_gnt !== 1'b1) begin bad++; $display("FAIL hw_gnt got=%b exp=1", obs_gnt); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0200, 8'h00, 11'd0);
        total++;
        if ({obs_gnt, obs_men, obs_mwe, obs_maddr, obs_mwd} !== {3'b111, 16'h0200, 8'h3C}) begin
            bad++; $display("FAIL hw_cmd got=%b%b%b %h %h exp=111 0200 3c", obs_gnt, obs_men, obs_mwe, obs_maddr, obs_mwd);
        end
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
        total++;
        if (obs_hv !== 1'b0) begin bad++; $display("FAIL hw_no_rvalid got=%b exp=0", obs_hv); end
        idle(1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
        total++;
        if ({obs_hv, obs_hd, obs_dv} !== {1'b1, 8'h3C, 1'b0}) begin
            bad++; $display("FAIL hr_ret got=%b %h %b exp=1 3c 0", obs_hv, obs_hd, obs_dv);
        end
        idle(3);
    endtask

    task automatic test_contention;
        int npulse = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(i < 5, 16'h1000 + 16'(i), i <= 5, 1'b0, 16'h0300, 8'h0, 11'd0);
            total++;
            if (obs_gnt !== (i == 5)) begin bad++; $display("FAIL cont_gnt i=%0d got=%b exp=%b", i, obs_gnt, i == 5); end
            if (obs_dv) begin
                total++;
                if (obs_dd !== init_val(16'h1000 + 16'(npulse))) begin
                    bad++; $display("FAIL cont_order k=%0d got=%h exp=%h", npulse, obs_dd, init_val(16'h1000 + 16'(npulse)));
                end
                npulse++;
            end
        end
        total++;
        if (npulse != 5) begin bad++; $display("FAIL cont_count got=%0d exp=5", npulse); end
        idle(3);
    endtask

    task automatic test_starvation;
        int npulse = 0;
        int at = -1;
        int ngnt = 0;
        for (int i = 0; i < 1400; i++) begin
            cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 16'h0400, 8'h0, 11'd0);
            if (obs_starved) begin npulse++; at = i; end
            if (obs_gnt) ngnt++;
        end
        total++;
        if (npulse != 1 || at != MAX_WAIT) begin
            bad++; $display("FAIL starve pulses=%0d at=%0d exp=1 at %0d", npulse, at, MAX_WAIT);
        end
        total++;
        if (ngnt != 0) begin bad++; $display("FAIL starve_gnt got=%0d exp=0", ngnt); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0400, 8'h0, 11'd0);
        total++;
        if ({obs_gnt, obs_starved} !== 2'b10) begin bad++; $display("FAIL starve_release got=%b exp=10", {obs_gnt, obs_starved}); end
        idle(4);
    endtask

    task automatic test_reset_midflight;
        int nvalid = 0;
        cycle(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
        #2;
        rstn_i = 1'b0;
        disp_req_i = 1'b0;
        #1;
        total++;
        if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, disp_valid_o, disp_data_o,
             host_rvalid_o, host_rdata_o, host_gnt_o, host_starved_o} !== 46'h0) begin
            bad++; $display("FAIL midreset got=%h exp=0", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
                disp_valid_o, disp_data_o, host_rvalid_o, host_rdata_o, host_gnt_o, host_starved_o});
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        cyc++;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 11'd0);
            if (obs_dv || obs_hv || obs_men) nvalid++;
        end
        total++;
        if (nvalid != 0) begin bad++; $display("FAIL midreset_after got=%0d exp=0", nvalid); end
    endtask

    task automatic test_random;
        logic        d, hr, hwe;
        logic [15:0] ha;
        logic [7:0]  hwd;
        hr = 1'b0; hwe = 1'b0; ha = '0; hwd = '0;
        for (int i = 0; i < 2000; i++) begin
            d = ($urandom_range(0, 99) < 55);
            if (!hr) begin
                hr  = ($urandom_range(0, 2) == 0);
                hwe = $urandom_range(0, 1) == 1;
                ha  = 16'($urandom_range(0, 31));
                hwd = 8'($urandom);
            end
            cycle(d, 16'($urandom_range(0, 31)), hr, hwe, ha, hwd, 11'($urandom_range(0, 805)));
            total++;
            if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, obs_gnt, exp_gnt); end
            total++;
            if ({obs_dv, obs_dd} !== {exp_dv, exp_dd}) begin
                bad++; $display("FAIL rnd_disp cyc=%0d got=%b %h exp=%b %h", cyc, obs_dv, obs_dd, exp_dv, exp_dd);
            end
            total++;
            if ({obs_hv, obs_hd} !== {exp_hv, exp_hd}) begin
                bad++; $display("FAIL rnd_host cyc=%0d got=%b %h exp=%b %h", cyc, obs_hv, obs_hd, exp_hv, exp_hd);
            end
            total++;
            if ({obs_men, obs_mwe} !== {exp_men, exp_mwe}) begin
                bad++; $display("FAIL rnd_cmd cyc=%0d got=%b%b exp=%b%b", cyc, obs_men, obs_mwe, exp_men, exp_mwe);
            end
            total++;
            if (obs_starved !== exp_starved) begin
                bad++; $display("FAIL rnd_starve cyc=%0d got=%b exp=%b", cyc, obs_starved, exp_starved);
            end
            if (exp_gnt) hr = 1'b0;
        end
        idle(4);
    endtask

`ifdef VRAM_ARB_VBLANK_LOCK_EN
    task automatic test_vblank_lock;
        int ngnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0500, 8'h0, 11'd100);
            if (obs_gnt) ngnt++;
        end
        total++;
        if (ngnt != 0) begin bad++; $display("FAIL lock_active got=%0d exp=0", ngnt); end
        cycle(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0500, 8'h0, 11'd0);
        total++;
        if (obs_gnt !== 1'b0) begin bad++; $display("FAIL lock_disp got=%b exp=0", obs_gnt); end
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0500, 8'h0, 11'd0);
        total++;
        if (obs_gnt !== 1'b1) begin bad++; $display("FAIL lock_vblank got=%b exp=1", obs_gnt); end
        idle(4);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_disp_read();
        test_host_write_read();
        test_contention();
        test_starvation();
`ifdef VRAM_ARB_VBLANK_LOCK_EN
        test_vblank_lock();
`endif
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
